mem_xfer_ctrl: RTL
==================

// Module: mem_xfer_ctrl
// PURPOSE
//  Sequencing controller for the memory-to-memory transfer path. Issues reads to the source
//  memory and writes to the destination memory. Timing accounts for the source memory read
//  latency plus the 8-bit transfer register between source DOut1 and destination DOut2.
//  Sits upstream of that register, driving source read addresses. Also drives the
//  destination write strobes that consume the register's output.
// PARAMETERS
//  ADDR_W   5  address width of both memories (depth 2**ADDR_W)
//  DATA_W   8  data width of transfer path (monitor input)
//  RD_LAT   1  source memory read latency in cycles (>=0); PIPE = RD_LAT+1
// PORTS
//  clock      in   1         single clock; all logic on rising edge
//  reset      in   1         synchronous, active-high reset
//  start      in   1         request transfer; sampled only in IDLE
//  src_base   in   ADDR_W    first source address; sampled with start
//  dst_base   in   ADDR_W    first destination address; sampled with start
//  len        in   ADDR_W+1  word count, 0..2**ADDR_W; sampled with start
//  rd_en      out  1         source memory read enable
//  rd_addr    out  ADDR_W    source memory read address
//  wr_en      out  1         destination memory write enable
//  wr_addr    out  ADDR_W    destination memory write address
//  wr_data    in   DATA_W    transfer-register output (DOut2), used by checksum only
//  busy       out  1         transfer in progress
//  done       out  1         one-cycle completion pulse
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; rd_en, wr_en, busy, done = 0; rd_addr, wr_addr = 0.
//  Reset clears pipeline contents; checksum = 0 when compiled in.
//  FSM states: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 latches src_base, dst_base, len. Next state is READ if len!=0, else DONE.
//  - READ: one read per cycle, rd_en=1, rd_addr=src_base+i, i=0..len-1.
//    After the last read, moves to DRAIN.
//  - DRAIN: rd_en=0; waits until the last write has been issued, then moves to DONE.
//  - DONE: done=1 for exactly one cycle, busy=0; returns to IDLE.
//  Timing, start sampled high at edge t: rd_en is high in cycles t+1..t+len.
//  wr_en is high in cycles t+1+PIPE..t+len+PIPE, with wr_addr=dst_base+i for write i.
//  done pulses in cycle t+len+PIPE+1.
//  busy is high from cycle t+1 through t+len+PIPE.
//  len=0: no rd_en/wr_en; done pulses in cycle t+1; busy stays 0.
//  Write strobe is a PIPE-deep shift of rd_en; write address is a PIPE-deep shift of the
//  issued index, offset by dst_base.
//  Addresses wrap modulo 2**ADDR_W (e.g. ADDR_W=5, base 30, len 4: 30,31,0,1).
//  len=2**ADDR_W is legal: covers the full memory with one wrap.
//  start while busy or in DONE: ignored, no queuing.
//  start coincident with reset: reset wins.
//  reset mid-transfer: all strobes 0 on the next cycle; in-flight writes are dropped;
//  no done pulse.
//  rd_addr and wr_addr hold their last value when the enable is low.
// CONFIGURATION
//  XFER_CSUM_EN defined:
//  - adds output csum [DATA_W-1:0].
//  - csum is cleared when a transfer is accepted.
//  - On each wr_en cycle, csum <= csum + wr_data, modulo 2**DATA_W.
//  - csum is stable and valid while done=1 and until the next accepted start.
//  XFER_CSUM_EN undefined: no csum port; wr_data is unused.
// TESTING
//  T1: reset 2 cycles -> all outputs 0, state IDLE; start during reset ignored.
//  T2: src=4, dst=16, len=3, RD_LAT=1, memory1[4..6]=00,FF,55.
//      -> rd_addr 4,5,6 in t+1..t+3; wr_en in t+3..t+5 at 16,17,18; done at t+6.
//      -> memory2[16..18]=00,FF,55.
//  T3: src=30, dst=0, len=4 -> rd_addr 30,31,0,1 and wr_addr 0..3; no extra strobes.
//  T4: len=0 -> done at t+1, busy never set, rd_en/wr_en never set.
//      Then len=32 -> 32 reads/writes and done at t+35.
//  T5: start pulses at t+2 and in the DONE cycle during a len=3 transfer
//      -> ignored, a single done only.
//  T6: reset asserted at t+3 of a len=8 transfer -> strobes 0 from t+4.
//      No done; a new start is accepted normally afterwards.
//  With XFER_CSUM_EN, T2 -> csum=8'h54 while done=1.

Source files
------------

// File: rtl/mem_xfer_ctrl.sv
// Memory-to-memory transfer sequencer: issues source reads and pipelined destination writes.
// Optional running checksum of written data is compiled in with `define XFER_CSUM_EN.
module mem_xfer_ctrl #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
`ifdef XFER_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  localparam int unsigned PIPE  = RD_LAT + 1;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic              busy_d;
  logic              done_d;
  logic [PIPE-1:0]   en_sr;
  logic [PIPE:0]     en_chain;
  logic              last_wr_c;

`ifdef XFER_CSUM_EN
  logic [DATA_W-1:0] csum_d;
`else
  logic              unused_wr_data;
  assign unused_wr_data = ^wr_data;
`endif

  // Write strobe is rd_en delayed by PIPE cycles; en_chain[k] is the strobe k cycles back.
  assign en_chain  = {en_sr, rd_en};
  assign wr_en     = en_sr[PIPE-1];
  assign last_wr_c = wr_en && (en_chain[PIPE-1:0] == '0);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (len != '0) ? S_READ : S_DONE;
      S_READ:  if (cnt_q == len_q) state_d = S_DRAIN;
      S_DRAIN: if (last_wr_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; registered below so every output comes from a flop
  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    wr_addr_d = wr_addr;
    busy_d    = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
`ifdef XFER_CSUM_EN
    csum_d    = csum;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src_base;
          dst_d = dst_base;
          len_d = len;
`ifdef XFER_CSUM_EN
          csum_d = '0;
`endif
          if (len != '0) begin
            rd_en_d   = 1'b1;
            rd_addr_d = src_base;
            cnt_d     = CNT_W'(1);
          end
        end
      end
      S_READ: begin
        if (state_d == S_READ) begin
          rd_en_d   = 1'b1;
          rd_addr_d = src_q + cnt_q[ADDR_W-1:0];
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    // Writes of one transfer are contiguous, so the first one restarts at dst and the rest increment
    if (en_chain[PIPE-1]) begin
      wr_addr_d = wr_en ? (wr_addr + ADDR_W'(1)) : dst_q;
    end
`ifdef XFER_CSUM_EN
    if (wr_en) begin
      csum_d = csum + wr_data;
    end
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      en_sr   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef XFER_CSUM_EN
      csum    <= '0;
`endif
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
      wr_addr <= wr_addr_d;
      en_sr   <= en_chain[PIPE-1:0];
      busy    <= busy_d;
      done    <= done_d;
`ifdef XFER_CSUM_EN
      csum    <= csum_d;
`endif
    end
  end

endmodule
